// File: rtl/md_unit_ctrl.sv
// Multiply/divide unit scheduler: decodes the E-stage MDU op, runs a latency counter, commits HI/LO.
// Optional madd/maddu/msub/msubu support (SPECIAL2) is enabled by defining MDU_MADD_EN.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_e,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    input  logic        d_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;

    logic [5:0] opc, fn;
    logic       is_special;
    logic       is_mult, is_multu, is_div, is_divu;
    logic       is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic       is_madd, is_maddu, is_msub, is_msubu;
    logic       is_launch, is_div_any;
    logic       unused_ok;

    assign opc        = instr_e[31:26];
    assign fn         = instr_e[5:0];
    assign unused_ok  = ^instr_e[25:6];
    assign is_special = (opc == 6'b000000);
    assign is_mult    = is_special && fn == 6'b011000;
    assign is_multu   = is_special && fn == 6'b011001;
    assign is_div     = is_special && fn == 6'b011010;
    assign is_divu    = is_special && fn == 6'b011011;
    assign is_mfhi    = is_special && fn == 6'b010000;
    assign is_mthi    = is_special && fn == 6'b010001;
    assign is_mflo    = is_special && fn == 6'b010010;
    assign is_mtlo    = is_special && fn == 6'b010011;

`ifdef MDU_MADD_EN
    logic is_special2;
    assign is_special2 = (opc == 6'b011100);
    assign is_madd     = is_special2 && fn == 6'b000000;
    assign is_maddu    = is_special2 && fn == 6'b000001;
    assign is_msub     = is_special2 && fn == 6'b000100;
    assign is_msubu    = is_special2 && fn == 6'b000101;
`else
    assign is_madd  = 1'b0;
    assign is_maddu = 1'b0;
    assign is_msub  = 1'b0;
    assign is_msubu = 1'b0;
`endif

    assign is_div_any = is_div | is_divu;
    assign is_launch  = is_mult | is_multu | is_div_any | is_madd | is_maddu | is_msub | is_msubu;

    assign start    = is_launch && state == IDLE;
    assign stall_md = d_is_md & (start | busy);
    assign md_rdata = is_mfhi ? hi : (is_mflo ? lo : 32'h0);

    // Sign-extending to 64 bits first makes the truncated 64x64 product the exact signed result.
    logic [63:0] sx_rs, sx_rt, prod_s, prod_u, acc;
    assign sx_rs  = {{32{rs_e[31]}}, rs_e};
    assign sx_rt  = {{32{rt_e[31]}}, rt_e};
    assign prod_s = sx_rs * sx_rt;
    assign prod_u = {32'h0, rs_e} * {32'h0, rt_e};
    assign acc    = {hi, lo};

    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic               div_zero;

    assign div_zero = (rt_e == 32'h0);

    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (!div_zero) begin
            quot_u = rs_e / rt_e;
            rem_u  = rs_e % rt_e;
            if (rs_e == 32'h8000_0000 && rt_e == 32'hFFFF_FFFF) begin
                quot_s = 32'sh8000_0000;
                rem_s  = 32'sh0;
            end else begin
                quot_s = $signed(rs_e) / $signed(rt_e);
                rem_s  = $signed(rs_e) % $signed(rt_e);
            end
        end
    end

    // Divide by zero latches the current HI/LO, so the commit leaves them unchanged.
    logic [63:0] result;
    always_comb begin
        result = acc;
        if (is_mult)                    result = prod_s;
        else if (is_multu)              result = prod_u;
        else if (is_div && !div_zero)   result = {rem_s, quot_s};
        else if (is_divu && !div_zero)  result = {rem_u, quot_u};
        else if (is_madd)               result = acc + prod_s;
        else if (is_maddu)              result = acc + prod_u;
        else if (is_msub)               result = acc - prod_s;
        else if (is_msubu)              result = acc - prod_u;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        {pend_hi, pend_lo} <= result;
                        cnt   <= is_div_any ? DIV_LAST : MULT_LAST;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        if (is_mthi) hi <= rs_e;
                        if (is_mtlo) lo <= rs_e;
                    end
                end
                RUN: begin
                    if (cnt == 4'd0) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multiply/divide unit scheduler for the pipelined MIPS core. It sits beside the E-stage ALU and decodes the E-stage instruction. It launches mult/div operations and sequences their multi-cycle latency with a counter FSM, and it commits results to the HI/LO registers. It also raises the D-stage stall that keeps a second MDU instruction out of E while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (and madd family when enabled); range 1..15
- DIV_CYCLES, 10, busy duration for div/divu; range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- instr_e  in  32  instruction currently in E stage (nop = 0x00000000)
- rs_e  in  32  forwarded rs operand in E
- rt_e  in  32  forwarded rt operand in E
- d_is_md  in  1  D-stage instruction is any MDU op (mult/multu/div/divu/mfhi/mflo/mthi/mtlo, plus madd family when enabled)
- start  out  1  combinational; E instr is mult/multu/div/divu (or madd family) and FSM is IDLE
- busy  out  1  registered; operation in flight
- stall_md  out  1  combinational; d_is_md & (start | busy)
- md_rdata  out  32  combinational; HI for mfhi, LO for mflo, else 0
- hi, lo  out  32 each  architectural HI/LO (debug/trace)

Clock and reset: one clock, `clk`. Reset `reset` is synchronous and active-high.

## Operation
- Decode on SPECIAL (opcode 000000) with these funct codes: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- FSM states:
  - IDLE → RUN on start. At launch:
    - latch the computed result into pending_hi/pending_lo;
    - cnt ← (mult ? MULT_CYCLES : DIV_CYCLES) − 1.
  - RUN: decrement cnt each cycle. When cnt == 0, write HI ← pending_hi and LO ← pending_lo, and go to IDLE.
- Arithmetic:
  - mult: signed 32×32 → 64, {HI,LO}.
  - multu: unsigned 32×32 → 64.
  - div: LO = signed quotient, HI = signed remainder, both truncated toward zero; the remainder takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero: HI/LO are left unchanged at commit, but the full DIV_CYCLES busy period still runs.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- mthi/mtlo: write HI/LO from rs_e at the clock edge ending the E cycle, only when IDLE. If issued while busy (a hazard-unit violation), the write is ignored.
- mfhi/mflo: md_rdata reflects the current HI/LO registers. A read in E while busy is only possible on a hazard-unit violation; in that case it returns the pre-commit value.
- A start while busy cannot occur because stall_md blocks it. If it occurs anyway, it is ignored.

## Timing
- Reset: busy = 0, FSM = IDLE, cnt = 0, HI = LO = 0, pending_hi = pending_lo = 0. Reset mid-RUN aborts the operation, discards the pending result, and leaves no commit.
- Launch at cycle k (start = 1), with N = MULT_CYCLES or DIV_CYCLES:
  - busy = 1 in cycles k+1 … k+N;
  - HI/LO are updated at the edge ending cycle k+N;
  - the new value is visible on hi/lo and md_rdata from cycle k+N+1;
  - busy = 0 in cycle k+N+1.
- stall_md:
  - high in cycle k (via start) and in cycles k+1 … k+N (via busy) whenever d_is_md = 1;
  - an MDU instruction held in D enters E at cycle k+N+2.
- Back-to-back: a new start is accepted in the first IDLE cycle (k+N+1). It is never accepted in the same cycle as the commit.
- Non-MDU instructions never stall and are unaffected by busy.

## Configuration
- Macro: MDU_MADD_EN.
- Defined: decode SPECIAL2 (opcode 011100) with these funct codes: madd 000000, maddu 000001, msub 000100, msubu 000101.
  - Pending result = {HI,LO} ± product, modulo 2^64, signed or unsigned per op.
  - The {HI,LO} used is the value at launch.
  - Latency is MULT_CYCLES.
  - These ops are included in start and are expected in d_is_md.
- Undefined: SPECIAL2 opcodes do not decode as MDU ops. start = 0, and HI/LO are untouched.

## Test plan
- mult rs = 0xFFFFFFFE (−2), rt = 3, started at cycle 10 → busy in cycles 11–15; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA from cycle 16; multu with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- div rs = −7 (0xFFFFFFF9), rt = 2 → busy 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; divu 7/0 with HI = 0x11, LO = 0x22 beforehand → HI/LO unchanged after 10 busy cycles.
- mult launched, then d_is_md = 1 (mflo waiting in D) → stall_md high from the start cycle through the last busy cycle, low at k+N+1; mflo in E returns the new LO.
- mthi rs = 0xDEADBEEF in E while IDLE → hi = 0xDEADBEEF next cycle; mfhi in the following E cycle → md_rdata = 0xDEADBEEF; a non-MDU instruction in D with busy = 1 → stall_md = 0.
- reset asserted in the 3rd busy cycle of a div → next cycle busy = 0, HI = LO = 0, and no later commit occurs.
- (MDU_MADD_EN) HI:LO = 0:0xFFFFFFFF, madd 1×1 → after 5 busy cycles HI = 1, LO = 0; without the macro, the same encoding gives start = 0 and HI/LO unchanged.
